priority_encoder_host: RTL and testbench
========================================

// Module: priority_encoder_host
// PURPOSE
//  Encoder host: inverse of the decoder host. Captures a 16-bit one-hot (or multi-hot) vector and
//  returns its 4-bit bit index, zero-extended to 8 bits, through the same 4-state enable-gated sequence.
//  Flags zero-hot and multi-hot inputs and reports the population count.
//  Keeps a 13-bit program-address counter and a count of completed encodes for the surrounding test harness.
// PARAMETERS
//  PRIORITY_MSB   1'b1       1: highest set index wins on multi-hot; 0: lowest set index wins
//  ZERO_CODE      8'hFF      encoded_output value when the captured vector is all zero
//  ADDR_INIT      13'h0000   value loaded into the address counter on reset
// PORTS
//  clk             in   1   single clock, all logic on rising edge
//  pon_rst_i       in   1   synchronous, active-high reset
//  decoded_input   in   16  one-hot vector to encode
//  encode_enable   in   1   advances the FSM, address counter and capture; low = hold
//  encoded_output  out  8   {4'b0,index}, or ZERO_CODE on zero-hot input
//  encode_valid    out  1   one-cycle strobe: the result outputs are valid
//  encode_error    out  1   captured vector was zero-hot; sticky until next S_IDLE
//  multi_hot       out  1   captured vector had >1 bit set; sticky until next S_IDLE
//  hot_count       out  5   popcount of captured vector (0..16)
//  encode_count    out  16  completed encodes, wraps 16'hFFFF->0
//  prog_adr_out    out  13  registered copy of the address counter
// BEHAVIOUR
//  Reset (pon_rst_i high at an edge)
//   - all outputs 0; state=S_IDLE; capture reg=0; addr=ADDR_INIT; prog_adr_out=0.
//   - Reset applies mid-sequence too: an in-flight encode is discarded, encode_count is not bumped.
//  FSM (2-bit state), transitions only on edges with encode_enable=1
//   - S_IDLE(0): encoded_output<=0, clear encode_error/multi_hot/hot_count, valid<=0 -> S_CAPTURE.
//   - S_CAPTURE(1): cap<=decoded_input -> S_ENCODE.
//   - S_ENCODE(2): index/flags/hot_count computed from cap (never from the live input) and registered.
//     encode_valid<=1 -> S_VALID.
//   - S_VALID(3): encode_valid<=0; encode_count<=encode_count+1 -> S_IDLE.
//  Enable low and other rules
//   - encode_enable=0 at an edge: state, cap and result outputs hold; encode_valid<=0.
//   - Dropping enable in S_VALID kills the strobe; the sequence resumes from S_VALID when enable returns.
//     encode_valid is not re-asserted; the count still increments when S_VALID completes.
//   - Latency with enable held high: input sampled at edge E+1 (state S_CAPTURE).
//     encode_valid is high in the cycle after edge E+2. One result every 4 cycles.
//  Encoding
//   - zero-hot: encoded_output=ZERO_CODE, encode_error=1, multi_hot=0, hot_count=0.
//   - multi-hot: index of the highest (PRIORITY_MSB=1) or lowest (0) set bit; multi_hot=1.
//   - Upper nibble of encoded_output is always 0 except for ZERO_CODE.
//  Address counter
//   - +1 on every enable edge, wraps 13'h1FFF->0.
//   - prog_adr_out<=addr every edge, so it lags the counter by one cycle.
//  Reachability: the 2-bit state has no unreachable encodings.
// TESTING
//  T1 reset: hold pon_rst_i 2 cycles, enable=1 -> all outputs 0, prog_adr_out=0 after release.
//  T2 one-hot sweep: enable=1, input=1<<k, k=0..15 -> encoded_output=k.
//     valid exactly 1 cycle per 4, no flags, hot_count=1, encode_count=16 at end.
//  T3 zero/multi: input 16'h0000 -> 8'hFF, encode_error=1. Input 16'h8421 -> 8'h0F, multi_hot=1, hot_count=4.
//     With PRIORITY_MSB=0 and input 16'h8421 -> 8'h00.
//  T4 capture isolation: input 16'h0010 at capture edge, changed to 16'h0400 next cycle -> encoded_output=8'h04.
//  T5 enable gaps: drop enable for 3 cycles in S_ENCODE and in S_VALID -> outputs hold, no extra valid.
//     encode_count increments once per sequence.
//  T6 wrap and mid-op reset: 8192 enable cycles from ADDR_INIT=0 -> prog_adr_out wraps to 0.
//     Reset asserted in S_ENCODE -> no valid, encode_count unchanged.

Source files
------------

// File: rtl/priority_encoder_host.sv
// priority_encoder_host
// Captures a 16-bit one-hot (or multi-hot) vector and returns its bit index,
// zero-extended to 8 bits, through a four-state enable-gated sequence.
// Also flags zero-hot / multi-hot captures, reports the population count,
// counts completed encodes and runs a 13-bit program-address counter.
module priority_encoder_host #(
    parameter logic        PRIORITY_MSB = 1'b1,
    parameter logic [7:0]  ZERO_CODE    = 8'hFF,
    parameter logic [12:0] ADDR_INIT    = 13'h0000
) (
    input  logic        clk,
    input  logic        pon_rst_i,
    input  logic [15:0] decoded_input,
    input  logic        encode_enable,
    output logic [7:0]  encoded_output,
    output logic        encode_valid,
    output logic        encode_error,
    output logic        multi_hot,
    output logic [4:0]  hot_count,
    output logic [15:0] encode_count,
    output logic [12:0] prog_adr_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ENCODE  = 2'd2,
        S_VALID   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] cap_r;
    logic [12:0] addr_r;
    logic [3:0]  index_s;
    logic [4:0]  pop_s;
    logic        zero_s;
    logic        multi_s;

    // Index of the winning set bit; the last hit in scan order wins, so the
    // scan direction selects highest-wins or lowest-wins priority.
    function automatic logic [3:0] find_index(input logic [15:0] vec,
                                              input logic       msb_first);
        logic [3:0] idx;
        idx = 4'd0;
        if (msb_first) begin
            for (int i = 0; i < 16; i++) begin
                if (vec[i]) begin
                    idx = 4'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = 4'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    // Number of set bits in a 16-bit vector (0..16).
    function automatic logic [4:0] pop_count(input logic [15:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'b0000, vec[i]};
        end
        return cnt;
    endfunction

    // Result decode works only on the captured copy, never the live input.
    always_comb begin
        index_s = find_index(cap_r, PRIORITY_MSB);
        pop_s   = pop_count(cap_r);
        zero_s  = (cap_r == 16'h0000);
        multi_s = (pop_s > 5'd1);
    end

    // Next-state logic: the sequence only advances on enabled edges.
    always_comb begin
        next_state_s = state_r;
        if (encode_enable) begin
            case (state_r)
                S_IDLE:    next_state_s = S_CAPTURE;
                S_CAPTURE: next_state_s = S_ENCODE;
                S_ENCODE:  next_state_s = S_VALID;
                S_VALID:   next_state_s = S_IDLE;
                default:   next_state_s = S_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture register, result outputs, strobe and completed-encode count.
    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            cap_r          <= 16'h0000;
            encoded_output <= 8'h00;
            encode_valid   <= 1'b0;
            encode_error   <= 1'b0;
            multi_hot      <= 1'b0;
            hot_count      <= 5'd0;
            encode_count   <= 16'h0000;
        end else if (!encode_enable) begin
            // Hold everything, but a strobe never survives a stalled edge.
            encode_valid <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    encoded_output <= 8'h00;
                    encode_error   <= 1'b0;
                    multi_hot      <= 1'b0;
                    hot_count      <= 5'd0;
                    encode_valid   <= 1'b0;
                end
                S_CAPTURE: begin
                    cap_r        <= decoded_input;
                    encode_valid <= 1'b0;
                end
                S_ENCODE: begin
                    if (zero_s) begin
                        encoded_output <= ZERO_CODE;
                        encode_error   <= 1'b1;
                        multi_hot      <= 1'b0;
                        hot_count      <= 5'd0;
                    end else begin
                        encoded_output <= {4'h0, index_s};
                        encode_error   <= 1'b0;
                        multi_hot      <= multi_s;
                        hot_count      <= pop_s;
                    end
                    encode_valid <= 1'b1;
                end
                S_VALID: begin
                    encode_valid <= 1'b0;
                    encode_count <= encode_count + 16'd1;
                end
                default: begin
                    encode_valid <= 1'b0;
                end
            endcase
        end
    end

    // Program-address counter; the output copy lags it by one edge.
    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            addr_r       <= ADDR_INIT;
            prog_adr_out <= 13'h0000;
        end else begin
            prog_adr_out <= addr_r;
            if (encode_enable) begin
                addr_r <= addr_r + 13'd1;
            end else begin
                addr_r <= addr_r;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_host.sv
// Directed bench for priority_encoder_host: a highest-wins instance and a
// lowest-wins instance share stimulus; expected values are hand-derived.
module tb_priority_encoder_host;

    logic        clk;
    logic        pon_rst_i;
    logic [15:0] decoded_input;
    logic        encode_enable;

    logic [7:0]  encoded_output;
    logic        encode_valid;
    logic        encode_error;
    logic        multi_hot;
    logic [4:0]  hot_count;
    logic [15:0] encode_count;
    logic [12:0] prog_adr_out;

    logic [7:0]  lsb_encoded_output;
    logic        lsb_encode_valid;
    logic        lsb_encode_error;
    logic        lsb_multi_hot;
    logic [4:0]  lsb_hot_count;
    logic [15:0] lsb_encode_count;
    logic [12:0] lsb_prog_adr_out;

    int          total;
    int          bad;
    int          exp_cnt;

    priority_encoder_host #(
        .PRIORITY_MSB (1'b1),
        .ZERO_CODE    (8'hFF),
        .ADDR_INIT    (13'h0000)
    ) dut (
        .clk            (clk),
        .pon_rst_i      (pon_rst_i),
        .decoded_input  (decoded_input),
        .encode_enable  (encode_enable),
        .encoded_output (encoded_output),
        .encode_valid   (encode_valid),
        .encode_error   (encode_error),
        .multi_hot      (multi_hot),
        .hot_count      (hot_count),
        .encode_count   (encode_count),
        .prog_adr_out   (prog_adr_out)
    );

    priority_encoder_host #(
        .PRIORITY_MSB (1'b0),
        .ZERO_CODE    (8'hFF),
        .ADDR_INIT    (13'h0000)
    ) dut_lsb (
        .clk            (clk),
        .pon_rst_i      (pon_rst_i),
        .decoded_input  (decoded_input),
        .encode_enable  (encode_enable),
        .encoded_output (lsb_encoded_output),
        .encode_valid   (lsb_encode_valid),
        .encode_error   (lsb_encode_error),
        .multi_hot      (lsb_multi_hot),
        .hot_count      (lsb_hot_count),
        .encode_count   (lsb_encode_count),
        .prog_adr_out   (lsb_prog_adr_out)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        pon_rst_i     = 1'b1;
        encode_enable = 1'b1;
        decoded_input = 16'h0000;
        tick();
        tick();
        pon_rst_i = 1'b0;
        exp_cnt   = 0;
    endtask

    // One full four-edge sequence starting from S_IDLE with enable high.
    task automatic do_encode(input string tag, input logic [15:0] v_cap, input logic [15:0] v_after,
                             input logic [7:0] e_code, input logic [7:0] e_lsb,
                             input logic e_err, input logic e_multi, input logic [4:0] e_hot);
        encode_enable = 1'b1;
        decoded_input = v_cap;
        tick();
        check_val({tag, "_valid_idle"}, 32'(encode_valid), 32'd0);
        tick();
        decoded_input = v_after;
        check_val({tag, "_valid_cap"}, 32'(encode_valid), 32'd0);
        tick();
        check_val({tag, "_valid"}, 32'(encode_valid), 32'd1);
        check_val({tag, "_code"}, 32'(encoded_output), 32'(e_code));
        check_val({tag, "_code_lsb"}, 32'(lsb_encoded_output), 32'(e_lsb));
        check_val({tag, "_err"}, 32'(encode_error), 32'(e_err));
        check_val({tag, "_multi"}, 32'(multi_hot), 32'(e_multi));
        check_val({tag, "_hot"}, 32'(hot_count), 32'(e_hot));
        check_val({tag, "_cnt_pre"}, 32'(encode_count), 32'(exp_cnt));
        tick();
        exp_cnt = exp_cnt + 1;
        check_val({tag, "_valid_end"}, 32'(encode_valid), 32'd0);
        check_val({tag, "_cnt"}, 32'(encode_count), 32'(exp_cnt));
        check_val({tag, "_code_hold"}, 32'(encoded_output), 32'(e_code));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        exp_cnt       = 0;
        pon_rst_i     = 1'b1;
        encode_enable = 1'b1;
        decoded_input = 16'h0000;

        // T1: reset state
        apply_reset();
        pon_rst_i = 1'b1;
        check_val("rst_code", 32'(encoded_output), 32'd0);
        check_val("rst_valid", 32'(encode_valid), 32'd0);
        check_val("rst_err", 32'(encode_error), 32'd0);
        check_val("rst_multi", 32'(multi_hot), 32'd0);
        check_val("rst_hot", 32'(hot_count), 32'd0);
        check_val("rst_cnt", 32'(encode_count), 32'd0);
        check_val("rst_adr", 32'(prog_adr_out), 32'd0);
        pon_rst_i     = 1'b0;
        encode_enable = 1'b0;
        tick();
        check_val("rel_adr", 32'(prog_adr_out), 32'd0);
        check_val("rel_valid", 32'(encode_valid), 32'd0);
        check_val("rel_code", 32'(encoded_output), 32'd0);

        // T2: one-hot sweep
        for (int k = 0; k < 16; k++) begin
            do_encode("sweep", 16'h0001 << k, 16'h0001 << k, 8'(k), 8'(k), 1'b0, 1'b0, 5'd1);
        end
        check_val("sweep_total", 32'(encode_count), 32'd16);

        // T3: zero-hot and multi-hot
        do_encode("zero",  16'h0000, 16'h0000, 8'hFF, 8'hFF, 1'b1, 1'b0, 5'd0);
        do_encode("m8421", 16'h8421, 16'h8421, 8'h0F, 8'h00, 1'b0, 1'b1, 5'd4);
        do_encode("mFFFF", 16'hFFFF, 16'hFFFF, 8'h0F, 8'h00, 1'b0, 1'b1, 5'd16);
        do_encode("m0180", 16'h0180, 16'h0180, 8'h08, 8'h07, 1'b0, 1'b1, 5'd2);

        // T4: capture isolation
        do_encode("iso", 16'h0010, 16'h0400, 8'h04, 8'h04, 1'b0, 1'b0, 5'd1);

        // T5: enable gaps in S_ENCODE and S_VALID
        encode_enable = 1'b1;
        decoded_input = 16'h0020;
        tick();
        tick();
        encode_enable = 1'b0;
        decoded_input = 16'h4000;
        for (int g = 0; g < 3; g++) begin
            tick();
            check_val("gapE_valid", 32'(encode_valid), 32'd0);
            check_val("gapE_code", 32'(encoded_output), 32'd0);
        end
        encode_enable = 1'b1;
        tick();
        check_val("gapE_rvalid", 32'(encode_valid), 32'd1);
        check_val("gapE_rcode", 32'(encoded_output), 32'h05);
        check_val("gapE_rhot", 32'(hot_count), 32'd1);
        encode_enable = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            check_val("gapV_valid", 32'(encode_valid), 32'd0);
            check_val("gapV_code", 32'(encoded_output), 32'h05);
            check_val("gapV_cnt", 32'(encode_count), 32'(exp_cnt));
        end
        encode_enable = 1'b1;
        tick();
        exp_cnt = exp_cnt + 1;
        check_val("gapV_end_valid", 32'(encode_valid), 32'd0);
        check_val("gapV_end_cnt", 32'(encode_count), 32'(exp_cnt));
        do_encode("post_gap", 16'h0200, 16'h0200, 8'h09, 8'h09, 1'b0, 1'b0, 5'd1);

        // T6: address wrap
        apply_reset();
        encode_enable = 1'b1;
        decoded_input = 16'h0001;
        for (int n = 0; n < 8192; n++) begin
            tick();
        end
        check_val("adr_top", 32'(prog_adr_out), 32'h1FFF);
        tick();
        check_val("adr_wrap", 32'(prog_adr_out), 32'h0000);
        tick();
        check_val("adr_wrap1", 32'(prog_adr_out), 32'h0001);

        // T6: reset while in S_ENCODE discards the in-flight encode
        apply_reset();
        do_encode("pre_rst", 16'h0008, 16'h0008, 8'h03, 8'h03, 1'b0, 1'b0, 5'd1);
        encode_enable = 1'b1;
        decoded_input = 16'h0002;
        tick();
        tick();
        pon_rst_i = 1'b1;
        tick();
        pon_rst_i = 1'b0;
        exp_cnt   = 0;
        check_val("midrst_valid", 32'(encode_valid), 32'd0);
        check_val("midrst_cnt", 32'(encode_count), 32'd0);
        check_val("midrst_code", 32'(encoded_output), 32'd0);
        do_encode("after_rst", 16'h1000, 16'h1000, 8'h0C, 8'h0C, 1'b0, 1'b0, 5'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
